// File: rtl/bidir_bus_arbiter.sv
// Direction and enable control for a shared bidirectional bus between
// two sides A and B, with turnaround gaps, hold limits and fair ties.
//
// Parameters:
//   TA_CYC   - undriven turnaround cycles before a direction change (1..15)
//   MAX_HOLD - max consecutive grant cycles while the other side waits (1..255)
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   req_a, req_b   - drive requests from side A (A->B) and side B (B->A)
//   ctrl           - buffer direction, 1 = A drives B, 0 = B drives A
//   oe             - buffer enable, 0 = both sides released
//   gnt_a, gnt_b   - bus ownership this cycle
//   busy           - arbiter is not in IDLE
module bidir_bus_arbiter #(
   parameter int TA_CYC   = 2,
   parameter int MAX_HOLD = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_a,
   input  logic req_b,
   output logic ctrl,
   output logic oe,
   output logic gnt_a,
   output logic gnt_b,
   output logic busy
);

   typedef enum logic [1:0] {
      IDLE,
      TA,
      XFER_A,
      XFER_B
   } state_t;

   localparam logic [3:0] TA_LAST   = 4'(TA_CYC - 1);
   localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   state_t     state_q, state_d;
   logic       ctrl_q, ctrl_d;
   logic       oe_q, oe_d;
   logic       gnt_a_q, gnt_a_d;
   logic       gnt_b_q, gnt_b_d;
   logic       busy_q, busy_d;
   logic [7:0] hold_q, hold_d;
   logic [3:0] ta_q, ta_d;
   // 1 = A was granted most recently, 0 = B
   logic       rr_a_q, rr_a_d;

   logic go_xfer, go_ta, go_idle;
   logic tgt_a;
   logic pick_a;
   logic own_a, own_req, oth_req;

   always_comb begin
      state_d = state_q;
      ctrl_d  = ctrl_q;
      oe_d    = oe_q;
      gnt_a_d = gnt_a_q;
      gnt_b_d = gnt_b_q;
      hold_d  = hold_q;
      ta_d    = ta_q;
      rr_a_d  = rr_a_q;
      go_xfer = 1'b0;
      go_ta   = 1'b0;
      go_idle = 1'b0;
      tgt_a   = 1'b0;
      pick_a  = 1'b0;
      own_a   = (state_q == XFER_A);
      own_req = own_a ? req_a : req_b;
      oth_req = own_a ? req_b : req_a;

      unique case (state_q)
         IDLE: begin
            if (req_a || req_b) begin
               pick_a = (req_a && req_b) ? ~rr_a_q : req_a;
               tgt_a  = pick_a;
               if (pick_a == ctrl_q) go_xfer = 1'b1;
               else                  go_ta   = 1'b1;
            end
         end
         TA: begin
            // ctrl already points at the pending side
            if (ta_q == TA_LAST) begin
               tgt_a = ctrl_q;
               if (ctrl_q ? req_a : req_b) go_xfer = 1'b1;
               else                        go_idle = 1'b1;
            end else begin
               ta_d = ta_q + 4'd1;
            end
         end
         XFER_A, XFER_B: begin
            tgt_a = ~own_a;
            if (!own_req) begin
               if (oth_req) go_ta   = 1'b1;
               else         go_idle = 1'b1;
            end else if (oth_req && hold_q >= HOLD_LAST) begin
               go_ta = 1'b1;
            end else begin
               hold_d = (hold_q >= HOLD_MAX) ? HOLD_MAX : hold_q + 8'd1;
            end
         end
         default: go_idle = 1'b1;
      endcase

      if (go_xfer) begin
         state_d = tgt_a ? XFER_A : XFER_B;
         ctrl_d  = tgt_a;
         oe_d    = 1'b1;
         gnt_a_d = tgt_a;
         gnt_b_d = ~tgt_a;
         rr_a_d  = tgt_a;
         hold_d  = 8'd0;
      end else if (go_ta) begin
         state_d = TA;
         ctrl_d  = tgt_a;
         oe_d    = 1'b0;
         gnt_a_d = 1'b0;
         gnt_b_d = 1'b0;
         ta_d    = 4'd0;
      end else if (go_idle) begin
         state_d = IDLE;
         oe_d    = 1'b0;
         gnt_a_d = 1'b0;
         gnt_b_d = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ctrl_q  <= 1'b0;
         oe_q    <= 1'b0;
         gnt_a_q <= 1'b0;
         gnt_b_q <= 1'b0;
         busy_q  <= 1'b0;
         hold_q  <= 8'd0;
         ta_q    <= 4'd0;
         rr_a_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         oe_q    <= oe_d;
         gnt_a_q <= gnt_a_d;
         gnt_b_q <= gnt_b_d;
         busy_q  <= busy_d;
         hold_q  <= hold_d;
         ta_q    <= ta_d;
         rr_a_q  <= rr_a_d;
      end
   end

   assign ctrl  = ctrl_q;
   assign oe    = oe_q;
   assign gnt_a = gnt_a_q;
   assign gnt_b = gnt_b_q;
   assign busy  = busy_q;

endmodule
